inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Front-end fetch stage feeding the branch predictor and the fetch output queue (FOQ). Holds the architectural fetch PC, fetches 32-bit words from the instruction cache, assembles RV32I/RV32C instructions at 2-byte alignment (including 32-bit instructions that straddle a word), pre-decodes branch/jump class and immediate, and pushes each instruction with its prediction into the FOQ. Applies predictor redirects and mispredict recovery, and stalls after JALR until the target resolves.

## Interface
- RESET_PC, 32'h0, PC loaded on reset
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- icache_req  out  1  fetch request, held until icache_valid
- icache_addr  out  32  word-aligned fetch address ([1:0]=0)
- icache_valid  in  1  one-cycle response strobe
- icache_data  in  32  fetched word
- branch  out  1  current issuing inst is conditional branch (B-type, c.beqz, c.bnez)
- imm  out  32  sign-extended branch offset
- inst_length  out  1  1 = 32-bit, 0 = 16-bit
- pc_out  out  32  PC of issuing inst (predictor pc_in)
- need_branch  in  1  predictor taken decision
- branch_addr  in  32  predictor next PC
- predict_fail  in  1  mispredict detected
- fail_addr  in  32  recovery PC
- foq_full  in  1  FOQ cannot accept
- foq_push  out  1  push strobe
- foq_inst  out  32  raw inst (16-bit zero-extended)
- foq_pc  out  32  inst PC
- foq_len  out  1  inst_length
- foq_pred  out  1  predicted taken (branches), 1 for JAL/C.J/C.JAL
- jalr_resolved  in  1  JALR target available
- jalr_target  in  32  JALR target

## Operation
- State: pc, one-word buffer {buf_valid, buf_tag[31:2], buf_data}, half_reg[15:0], hi_ready, FSM.
- FSM states: ISSUE, WAIT_LO, WAIT_HI, DISCARD, STALL.
- ISSUE, inst available when buf hit on pc[31:2] and (pc[1]=0, or upper half compressed), or hi_ready. Length: bits[1:0]!=2'b11 → 16-bit.
- ISSUE, buf miss: icache_req for {pc[31:2],2'b00} → WAIT_LO.
- ISSUE, pc[1]=1, upper half 32-bit, not hi_ready: half_reg <= buf_data[31:16], request word pc[31:2]+1 → WAIT_HI.
- WAIT_LO on valid: buffer <= (pc[31:2], data) → ISSUE. WAIT_HI on valid: buffer <= (pc[31:2]+1, data), hi_ready <= 1, inst = {data[15:0], half_reg} → ISSUE.
- Issue fires when inst available, !foq_full, !predict_fail: foq_push=1; hi_ready <= 0.
  - Branch: pc <= branch_addr; foq_pred=need_branch.
  - JAL/C.J/C.JAL: pc <= pc+imm (J/CJ imm computed internally), foq_pred=1; branch=0.
  - JALR/C.JR/C.JALR: pc <= pc+len → STALL.
  - Else: pc <= pc + (len ? 4 : 2), 32-bit wrap.
- STALL: on jalr_resolved pc <= jalr_target → ISSUE.
- predict_fail (highest priority, any state): pc <= fail_addr, hi_ready <= 0, no push. WAIT_* without valid this cycle → DISCARD; with valid, buffer written normally → ISSUE. STALL → ISSUE.
- DISCARD: req dropped; wait for icache_valid, data discarded → ISSUE.
- Buffer never invalidated except reset (no self-modifying code).

## Timing
- Reset: pc=RESET_PC, FSM=ISSUE, buf_valid=0, hi_ready=0; all outputs 0.
- branch/imm/inst_length/pc_out combinational from registered state, valid only in ISSUE with inst available; 0 otherwise.
- Buffer hit: one inst per cycle. Miss: request cycle + cache latency + 1 issue cycle.
- icache_req/addr stable until valid; at most one outstanding request.
- foq_full in issue cycle: no push, pc held, predictor sees no push (its need_predict gated identically).
- rdy_in=0: no state change, foq_push=0.

## Structure
- Shared macros header: RESET_PC default, opcode constants (OP_BRANCH 7'b1100011, OP_JAL, OP_JALR), C quadrant/funct3 codes, FSM encodings.
- Sub-module `inst_predecode` (combinational): length, class, B/CB/J/CJ immediates.

## Test plan
- Reset, RESET_PC=0, word 0x00000013 at 0, 0x00100093 at 4 → two pushes pc 0,4, len 1, one cache access each.
- Compressed pair 0x45014581 at 0x10 → pushes pc 0x10 (0x4581) and 0x12 (0x4501), one cache access.
- pc=0x22, buffer half 0x0093 at upper, next word 0x????0010 → WAIT_HI, push foq_inst=0x00100093, pc 0x22, next pc 0x26.
- BEQ at 0x30, imm=+8, need_branch=1, branch_addr=0x38 → branch=1, imm=8, push foq_pred=1, next pc 0x38.
- predict_fail with fail_addr=0x100 while in WAIT_LO, valid 2 cycles later → DISCARD, stale data dropped, next fetch 0x100.
- JALR at 0x40 → push, STALL; foq_full ignored; jalr_resolved target 0x200 → fetch 0x200.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the fetch front end: reset PC, RV32I/RV32C
// control-flow encodings and the fetch FSM state type.
package inst_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] C_Q1 = 2'b01;
    localparam logic [1:0] C_Q2 = 2'b10;

    localparam logic [2:0] C1_JAL  = 3'b001;
    localparam logic [2:0] C1_J    = 3'b101;
    localparam logic [2:0] C1_BEQZ = 3'b110;
    localparam logic [2:0] C1_BNEZ = 3'b111;
    localparam logic [2:0] C2_JR   = 3'b100;

    typedef enum logic [2:0] {
        ST_ISSUE   = 3'd0,
        ST_WAIT_LO = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_DISCARD = 3'd3,
        ST_STALL   = 3'd4
    } fetch_state_t;

    // A parcel whose low two bits are not 2'b11 is a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] low_bits);
        return (low_bits != 2'b11);
    endfunction

endpackage

// File: rtl/inst_predecode.sv
// Combinational pre-decoder: instruction length, control-flow class and
// the sign-extended B/J/CB/CJ offset of the instruction at the fetch PC.
module inst_predecode
    import inst_fetch_unit_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_long,
    output logic        is_branch,
    output logic        is_jal,
    output logic        is_jalr,
    output logic [31:0] imm
);

    logic [31:0] imm_b_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm_cb_s;
    logic [31:0] imm_cj_s;

    assign imm_b_s  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j_s  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_cb_s = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                       inst[4:3], 1'b0};
    assign imm_cj_s = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6],
                       inst[7], inst[2], inst[11], inst[5:3], 1'b0};

    // Classify the instruction and pick the matching offset
    always_comb begin
        is_long   = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        imm       = 32'h0000_0000;
        if (!is_compressed(inst[1:0])) begin
            is_long = 1'b1;
            case (inst[6:0])
                OP_BRANCH: begin is_branch = 1'b1; imm = imm_b_s; end
                OP_JAL:    begin is_jal    = 1'b1; imm = imm_j_s; end
                OP_JALR:   is_jalr = 1'b1;
                default:   imm = 32'h0000_0000;
            endcase
        end else if (inst[1:0] == C_Q1) begin
            case (inst[15:13])
                C1_JAL, C1_J:     begin is_jal    = 1'b1; imm = imm_cj_s; end
                C1_BEQZ, C1_BNEZ: begin is_branch = 1'b1; imm = imm_cb_s; end
                default:          imm = 32'h0000_0000;
            endcase
        end else if (inst[1:0] == C_Q2) begin
            // c.jr / c.jalr: rs1 != 0, rs2 == 0 (bit 12 picks link or not)
            if ((inst[15:13] == C2_JR) && (inst[11:7] != 5'd0) && (inst[6:2] == 5'd0)) begin
                is_jalr = 1'b1;
            end else begin
                is_jalr = 1'b0;
            end
        end else begin
            imm = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one-word instruction buffer, 2-byte aligned instruction
// assembly (including word-straddling 32-bit instructions), redirect and
// mispredict handling, JALR stall, and push into the fetch output queue.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    output logic        branch,
    output logic [31:0] imm,
    output logic        inst_length,
    output logic [31:0] pc_out,
    input  logic        need_branch,
    input  logic [31:0] branch_addr,
    input  logic        predict_fail,
    input  logic [31:0] fail_addr,
    input  logic        foq_full,
    output logic        foq_push,
    output logic [31:0] foq_inst,
    output logic [31:0] foq_pc,
    output logic        foq_len,
    output logic        foq_pred,
    input  logic        jalr_resolved,
    input  logic [31:0] jalr_target
);

    fetch_state_t state_r, state_next_s;
    logic [31:0]  pc_r, pc_next_s;
    logic         buf_valid_r, buf_valid_next_s;
    logic [29:0]  buf_tag_r, buf_tag_next_s;
    logic [31:0]  buf_data_r, buf_data_next_s;
    logic [15:0]  half_reg_r, half_reg_next_s;
    logic         hi_ready_r, hi_ready_next_s;
    logic         req_r, req_next_s;
    logic [31:0]  addr_r, addr_next_s;

    logic        hit_s, avail_s, need_hi_s, miss_s, issue_ok_s, fire_s;
    logic [31:0] cand_s, inst_s, step_s;
    logic        pd_long_s, pd_branch_s, pd_jal_s, pd_jalr_s;
    logic [31:0] pd_imm_s;

    inst_predecode u_predecode (
        .inst      (cand_s),
        .is_long   (pd_long_s),
        .is_branch (pd_branch_s),
        .is_jal    (pd_jal_s),
        .is_jalr   (pd_jalr_s),
        .imm       (pd_imm_s)
    );

    // Locate the instruction at pc in the buffer / straddle assembly
    always_comb begin
        hit_s     = buf_valid_r && (buf_tag_r == pc_r[31:2]);
        avail_s   = 1'b0;
        need_hi_s = 1'b0;
        miss_s    = 1'b0;
        cand_s    = 32'h0000_0000;
        if (hi_ready_r) begin
            avail_s = 1'b1;
            cand_s  = {buf_data_r[15:0], half_reg_r};
        end else if (hit_s && !pc_r[1]) begin
            avail_s = 1'b1;
            cand_s  = buf_data_r;
        end else if (hit_s && is_compressed(buf_data_r[17:16])) begin
            avail_s = 1'b1;
            cand_s  = {16'h0000, buf_data_r[31:16]};
        end else if (hit_s) begin
            need_hi_s = 1'b1;
        end else begin
            miss_s = 1'b1;
        end
    end

    assign inst_s     = pd_long_s ? cand_s : {16'h0000, cand_s[15:0]};
    assign step_s     = pd_long_s ? 32'd4 : 32'd2;
    assign issue_ok_s = (state_r == ST_ISSUE) && avail_s;
    assign fire_s     = issue_ok_s && rdy_in && !foq_full && !predict_fail;

    assign branch      = issue_ok_s && pd_branch_s;
    assign imm         = issue_ok_s ? pd_imm_s : 32'h0000_0000;
    assign inst_length = issue_ok_s && pd_long_s;
    assign pc_out      = issue_ok_s ? pc_r : 32'h0000_0000;

    assign foq_push = fire_s;
    assign foq_inst = fire_s ? inst_s : 32'h0000_0000;
    assign foq_pc   = fire_s ? pc_r : 32'h0000_0000;
    assign foq_len  = fire_s && pd_long_s;
    assign foq_pred = fire_s && (pd_jal_s || (pd_branch_s && need_branch));

    assign icache_req  = req_r;
    assign icache_addr = addr_r;

    // Next-state and next-PC decision for the fetch FSM
    always_comb begin
        state_next_s     = state_r;
        pc_next_s        = pc_r;
        buf_valid_next_s = buf_valid_r;
        buf_tag_next_s   = buf_tag_r;
        buf_data_next_s  = buf_data_r;
        half_reg_next_s  = half_reg_r;
        hi_ready_next_s  = hi_ready_r;
        req_next_s       = req_r;
        addr_next_s      = addr_r;
        if (predict_fail) begin
            pc_next_s       = fail_addr;
            hi_ready_next_s = 1'b0;
            case (state_r)
                ST_WAIT_LO, ST_WAIT_HI: begin
                    req_next_s = 1'b0;
                    if (icache_valid) begin
                        buf_valid_next_s = 1'b1;
                        buf_tag_next_s   = addr_r[31:2];
                        buf_data_next_s  = icache_data;
                        state_next_s     = ST_ISSUE;
                    end else begin
                        state_next_s = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (icache_valid) begin
                        state_next_s = ST_ISSUE;
                    end else begin
                        state_next_s = ST_DISCARD;
                    end
                end
                default: state_next_s = ST_ISSUE;
            endcase
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (fire_s) begin
                        hi_ready_next_s = 1'b0;
                        if (pd_branch_s) begin
                            pc_next_s = branch_addr;
                        end else if (pd_jal_s) begin
                            pc_next_s = pc_r + pd_imm_s;
                        end else if (pd_jalr_s) begin
                            pc_next_s    = pc_r + step_s;
                            state_next_s = ST_STALL;
                        end else begin
                            pc_next_s = pc_r + step_s;
                        end
                    end else if (need_hi_s) begin
                        half_reg_next_s = buf_data_r[31:16];
                        addr_next_s     = {pc_r[31:2] + 30'd1, 2'b00};
                        req_next_s      = 1'b1;
                        state_next_s    = ST_WAIT_HI;
                    end else if (miss_s) begin
                        addr_next_s  = {pc_r[31:2], 2'b00};
                        req_next_s   = 1'b1;
                        state_next_s = ST_WAIT_LO;
                    end else begin
                        state_next_s = ST_ISSUE;
                    end
                end
                ST_WAIT_LO, ST_WAIT_HI: begin
                    if (icache_valid) begin
                        buf_valid_next_s = 1'b1;
                        buf_tag_next_s   = addr_r[31:2];
                        buf_data_next_s  = icache_data;
                        hi_ready_next_s  = (state_r == ST_WAIT_HI);
                        req_next_s       = 1'b0;
                        state_next_s     = ST_ISSUE;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_DISCARD: begin
                    if (icache_valid) begin
                        state_next_s = ST_ISSUE;
                    end else begin
                        state_next_s = ST_DISCARD;
                    end
                end
                ST_STALL: begin
                    if (jalr_resolved) begin
                        pc_next_s    = jalr_target;
                        state_next_s = ST_ISSUE;
                    end else begin
                        state_next_s = ST_STALL;
                    end
                end
                default: state_next_s = ST_ISSUE;
            endcase
        end
    end

    // State register; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r     <= ST_ISSUE;
            pc_r        <= RESET_PC;
            buf_valid_r <= 1'b0;
            buf_tag_r   <= 30'd0;
            buf_data_r  <= 32'h0000_0000;
            half_reg_r  <= 16'h0000;
            hi_ready_r  <= 1'b0;
            req_r       <= 1'b0;
            addr_r      <= 32'h0000_0000;
        end else if (rdy_in) begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            buf_valid_r <= buf_valid_next_s;
            buf_tag_r   <= buf_tag_next_s;
            buf_data_r  <= buf_data_next_s;
            half_reg_r  <= half_reg_next_s;
            hi_ready_r  <= hi_ready_next_s;
            req_r       <= req_next_s;
            addr_r      <= addr_next_s;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: the bench plays the instruction
// cache and the predictor, and checks every push against hand values.
module tb_inst_fetch_unit;

    logic        clk_in, rst_in, rdy_in;
    logic        icache_req, icache_valid;
    logic [31:0] icache_addr, icache_data;
    logic        branch, inst_length, need_branch, predict_fail;
    logic [31:0] imm, pc_out, branch_addr, fail_addr;
    logic        foq_full, foq_push, foq_len, foq_pred, jalr_resolved;
    logic [31:0] foq_inst, foq_pc, jalr_target;

    int total = 0;
    int bad   = 0;

    inst_fetch_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_valid(icache_valid), .icache_data(icache_data),
        .branch(branch), .imm(imm), .inst_length(inst_length), .pc_out(pc_out),
        .need_branch(need_branch), .branch_addr(branch_addr),
        .predict_fail(predict_fail), .fail_addr(fail_addr),
        .foq_full(foq_full), .foq_push(foq_push), .foq_inst(foq_inst),
        .foq_pc(foq_pc), .foq_len(foq_len), .foq_pred(foq_pred),
        .jalr_resolved(jalr_resolved), .jalr_target(jalr_target)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, answer one cycle later.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < 16; i++) begin
            if (icache_req === 1'b1) break;
            tick();
        end
        chkb("req_seen", icache_req, 1'b1);
        chk("req_addr", icache_addr, addr);
        tick();
        chkb("req_held", icache_req, 1'b1);
        chk("addr_held", icache_addr, addr);
        icache_valid = 1'b1;
        icache_data  = data;
        tick();
        icache_valid = 1'b0;
        icache_data  = 32'h0000_0000;
        #1;
    endtask

    task automatic expect_push(input logic [31:0] pc, input logic [31:0] inst,
                               input logic len, input logic pred);
        chkb("push", foq_push, 1'b1);
        chk("foq_pc", foq_pc, pc);
        chk("foq_inst", foq_inst, inst);
        chkb("foq_len", foq_len, len);
        chkb("foq_pred", foq_pred, pred);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; icache_valid = 1'b0; icache_data = 32'h0;
        need_branch = 1'b0; branch_addr = 32'h0; predict_fail = 1'b0; fail_addr = 32'h0;
        foq_full = 1'b0; jalr_resolved = 1'b0; jalr_target = 32'h0;
        tick(); tick(); #1;
        chkb("rst_req", icache_req, 1'b0);
        chk("rst_addr", icache_addr, 32'h0);
        chkb("rst_push", foq_push, 1'b0);
        chk("rst_pc_out", pc_out, 32'h0);
        chkb("rst_len", inst_length, 1'b0);
        chkb("rst_branch", branch, 1'b0);
        rst_in = 1'b0;

        // Two sequential 32-bit words
        fetch(32'h0, 32'h0000_0013);
        expect_push(32'h0, 32'h0000_0013, 1'b1, 1'b0);
        tick();
        chkb("miss_no_push", foq_push, 1'b0);
        chkb("miss_req_cycle", icache_req, 1'b0);
        fetch(32'h4, 32'h0010_0093);
        expect_push(32'h4, 32'h0010_0093, 1'b1, 1'b0);
        tick();

        // JAL +8 at 0x8
        fetch(32'h8, 32'h0080_006F);
        expect_push(32'h8, 32'h0080_006F, 1'b1, 1'b1);
        chkb("jal_not_branch", branch, 1'b0);
        tick();

        // Compressed pair at 0x10, first issue slot frozen by rdy_in
        fetch(32'h10, 32'h4501_4581);
        rdy_in = 1'b0; #1;
        chkb("rdy_low_push", foq_push, 1'b0);
        tick();
        rdy_in = 1'b1; #1;
        chk("rdy_pc_held", pc_out, 32'h10);
        expect_push(32'h10, 32'h0000_4581, 1'b0, 1'b0);
        tick();
        expect_push(32'h12, 32'h0000_4501, 1'b0, 1'b0);
        chkb("pair_one_access", icache_req, 1'b0);
        tick();

        // C.J +12 at 0x14 -> 0x20
        fetch(32'h14, 32'h0000_A031);
        expect_push(32'h14, 32'h0000_A031, 1'b0, 1'b1);
        tick();

        // c.nop at 0x20, then 32-bit inst straddling 0x22..0x25
        fetch(32'h20, 32'h0093_0001);
        expect_push(32'h20, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        chkb("straddle_no_push", foq_push, 1'b0);
        chk("straddle_pc_out", pc_out, 32'h0);
        fetch(32'h24, 32'hA029_0010);
        expect_push(32'h22, 32'h0010_0093, 1'b1, 1'b0);
        tick();
        expect_push(32'h26, 32'h0000_A029, 1'b0, 1'b1);
        chkb("upper_hit_no_req", icache_req, 1'b0);
        tick();

        // BEQ +8 at 0x30, first held by foq_full
        fetch(32'h30, 32'h0000_0463);
        need_branch = 1'b1; branch_addr = 32'h38; foq_full = 1'b1; #1;
        chkb("beq_branch", branch, 1'b1);
        chk("beq_imm", imm, 32'h8);
        chkb("beq_len", inst_length, 1'b1);
        chkb("full_no_push", foq_push, 1'b0);
        tick();
        foq_full = 1'b0; #1;
        chk("full_pc_held", pc_out, 32'h30);
        expect_push(32'h30, 32'h0000_0463, 1'b1, 1'b1);
        tick();
        need_branch = 1'b0; #1;

        // Mispredict while waiting on 0x38 -> DISCARD, then fetch 0x100
        tick();
        chkb("wait_lo_req", icache_req, 1'b1);
        chk("wait_lo_addr", icache_addr, 32'h38);
        predict_fail = 1'b1; fail_addr = 32'h100;
        tick();
        predict_fail = 1'b0; #1;
        chkb("discard_req_dropped", icache_req, 1'b0);
        tick();
        icache_valid = 1'b1; icache_data = 32'h0080_006F; #1;
        chkb("discard_no_push", foq_push, 1'b0);
        tick();
        icache_valid = 1'b0; icache_data = 32'h0; #1;
        chkb("stale_not_issued", foq_push, 1'b0);
        fetch(32'h100, 32'h0000_0013);

        // Mispredict in ISSUE with inst available: no push, go to 0x40
        predict_fail = 1'b1; fail_addr = 32'h40; #1;
        chkb("fail_no_push", foq_push, 1'b0);
        chk("fail_pc_out", pc_out, 32'h100);
        tick();
        predict_fail = 1'b0; #1;

        // JALR at 0x40 -> STALL until target 0x200
        fetch(32'h40, 32'h0000_8067);
        expect_push(32'h40, 32'h0000_8067, 1'b1, 1'b0);
        tick();
        foq_full = 1'b1; #1;
        chkb("stall_no_push", foq_push, 1'b0);
        tick(); tick();
        chkb("stall_no_req", icache_req, 1'b0);
        jalr_resolved = 1'b1; jalr_target = 32'h200;
        tick();
        jalr_resolved = 1'b0; foq_full = 1'b0; #1;
        fetch(32'h200, 32'h0000_8082);
        expect_push(32'h200, 32'h0000_8082, 1'b0, 1'b0);
        tick();
        chkb("cjr_stall_no_push", foq_push, 1'b0);
        chkb("cjr_stall_no_req", icache_req, 1'b0);
        jalr_resolved = 1'b1; jalr_target = 32'h300;
        tick();
        jalr_resolved = 1'b0; #1;
        fetch(32'h300, 32'h0000_0013);
        expect_push(32'h300, 32'h0000_0013, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
